// File: rtl/rs_drive_ctrl.sv
// rs_drive_ctrl: synchronises, debounces and arbitrates set/reset requests into clean S/R pulses.
// Defining RS_FEEDBACK_SKIP_EN drops requests that Q_Fb shows are already satisfied.
module rs_drive_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int PULSE_W   = 2,
  parameter int GAP_W     = 1
) (
  input  logic Clk,
  input  logic Reset_L,
  input  logic E,
  input  logic Set_Req,
  input  logic Rst_Req,
  input  logic Q_Fb,
  output logic S,
  output logic R,
  output logic Busy,
  output logic Conflict
);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int PMAX = PULSE_W > GAP_W ? PULSE_W : GAP_W;
  localparam int PW = $clog2(PMAX + 1);
  localparam logic [DW-1:0] DBL = DW'(DB_CYCLES - 1);
  localparam logic [PW-1:0] PL = PW'(PULSE_W - 1);
  localparam logic [PW-1:0] GL = PW'(GAP_W > 0 ? GAP_W - 1 : 0);

  typedef enum logic [1:0] {IDLE, PULSE_S, PULSE_R, GAP} state_t;

  state_t state_q, state_d;
  logic [1:0] s1_q, s2_q, db_q, db_d, dbp_q;
  logic [DW-1:0] dcnt_q [2];
  logic [DW-1:0] dcnt_d [2];
  logic set_pend_q, set_pend_d, rst_pend_q, rst_pend_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic set_ev, rst_ev, idle, skip_s, skip_r, start_s, start_r, pl, gl;

`ifdef RS_FEEDBACK_SKIP_EN
  logic [1:0] qs_q;
  always_ff @(posedge Clk or negedge Reset_L)
    if (!Reset_L) qs_q <= '0;
    else qs_q <= {qs_q[0], Q_Fb};
  assign skip_r = idle & rst_pend_q & ~qs_q[1];
  assign skip_s = idle & set_pend_q & qs_q[1];
`else
  logic unused_q_fb;
  assign unused_q_fb = Q_Fb;
  assign skip_r = 1'b0;
  assign skip_s = 1'b0;
`endif

  // channel 0 = set, channel 1 = reset
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dcnt_d[i] = (s2_q[i] == db_q[i] || dcnt_q[i] == DBL) ? '0 : dcnt_q[i] + 1'b1;
      db_d[i] = (s2_q[i] != db_q[i] && dcnt_q[i] == DBL) ? s2_q[i] : db_q[i];
    end
  end

  assign set_ev  = db_q[0] & ~dbp_q[0];
  assign rst_ev  = db_q[1] & ~dbp_q[1];
  assign idle    = state_q == IDLE;
  assign start_r = idle & E & rst_pend_q & ~skip_r;
  assign start_s = idle & E & set_pend_q & ~skip_s & ~(rst_pend_q & ~skip_r);
  assign pl      = pcnt_q == PL;
  assign gl      = pcnt_q == GL;

  always_comb begin
    rst_pend_d = rst_ev | (rst_pend_q & ~start_r & ~skip_r);
    set_pend_d = (set_ev & ~rst_ev) | (set_pend_q & ~start_s & ~skip_s);
    state_d = idle ? (start_r ? PULSE_R : start_s ? PULSE_S : IDLE)
            : state_q == GAP ? (gl ? IDLE : GAP)
            : pl ? (GAP_W == 0 ? IDLE : GAP) : state_q;
    pcnt_d = (idle || (state_q == GAP ? gl : pl)) ? '0 : pcnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      s1_q       <= '0;
      s2_q       <= '0;
      db_q       <= '0;
      dbp_q      <= '0;
      dcnt_q     <= '{default: '0};
      set_pend_q <= 1'b0;
      rst_pend_q <= 1'b0;
      state_q    <= IDLE;
      pcnt_q     <= '0;
      S          <= 1'b0;
      R          <= 1'b0;
      Busy       <= 1'b0;
      Conflict   <= 1'b0;
    end else begin
      s1_q       <= {Rst_Req, Set_Req};
      s2_q       <= s1_q;
      db_q       <= db_d;
      dbp_q      <= db_q;
      dcnt_q     <= dcnt_d;
      set_pend_q <= set_pend_d;
      rst_pend_q <= rst_pend_d;
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      S          <= state_d == PULSE_S;
      R          <= state_d == PULSE_R;
      Busy       <= state_d != IDLE;
      Conflict   <= set_ev & rst_ev;
    end
  end
endmodule

// File: tb/tb_rs_drive_ctrl.sv
// tb_rs_drive_ctrl: vector table plus corner sequences; observed S/R/Conflict pulses are matched
// against an expected-event queue, with a behavioural RS flip-flop closing the Q_Fb loop.
module tb_rs_drive_ctrl;
  logic Clk = 1'b0;
  logic Reset_L = 1'b0;
  logic E = 1'b0;
  logic Set_Req = 1'b0;
  logic Rst_Req = 1'b0;
  logic Q_Fb = 1'b0;
  logic S, R, Busy, Conflict;

`ifdef RS_FEEDBACK_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    int kind;
    int at;
    int w;
  } ev_t;

  typedef struct {
    int s_at;
    int s_len;
    int r_at;
    int r_len;
    int e;
    int q0;
    int exp_s;
    int exp_r;
    int exp_c;
    int busy;
  } vec_t;

  ev_t exp_q[$];
  vec_t vt[10];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int base = 0;
  int sn = 0, rn = 0, cn = 0, sw = 0, rw = 0, cw = 0;
  logic sp = 1'b0, rp = 1'b0, cp = 1'b0;

  rs_drive_ctrl dut (
    .Clk(Clk),
    .Reset_L(Reset_L),
    .E(E),
    .Set_Req(Set_Req),
    .Rst_Req(Rst_Req),
    .Q_Fb(Q_Fb),
    .S(S),
    .R(R),
    .Busy(Busy),
    .Conflict(Conflict)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int at, input int w);
    exp_q.push_back('{kind, at, w});
  endtask

  task automatic take(input int kind, output int w);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_pulse_kind", kind, -1);
      w = 0;
    end else begin
      e = exp_q.pop_front();
      chk("pulse_kind", kind, e.kind);
      chk("pulse_cycle", cyc, e.at);
      w = e.w;
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    #1;
    Reset_L = 1'b0;
    Set_Req = 1'b0;
    Rst_Req = 1'b0;
    E = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset_L = 1'b1;
    busy_cnt = 0;
  endtask

  // kinds: 0 = S pulse, 1 = R pulse, 2 = Conflict pulse
  initial begin
    forever begin
      @(negedge Clk);
      chk("s_and_r", int'(S & R), 0);
      if (Busy) busy_cnt++;
      if (Conflict && !cp) begin take(2, cw); cn = 0; end
      if (Conflict) cn++;
      if (!Conflict && cp) chk("conflict_width", cn, cw);
      if (R && !rp) begin take(1, rw); rn = 0; end
      if (R) rn++;
      if (!R && rp) chk("r_width", rn, rw);
      if (S && !sp) begin take(0, sw); sn = 0; end
      if (S) sn++;
      if (!S && sp) chk("s_width", sn, sw);
      cp = Conflict;
      rp = R;
      sp = S;
      if (S) Q_Fb = 1'b1;
      else if (R) Q_Fb = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //         s_at s_len r_at r_len e q0 exp_s exp_r exp_c busy
    vt[0] = '{2, 30, 0, 0, 1, 0, 10, -1, -1, 3};
    vt[1] = '{0, 0, 2, 30, 1, 1, -1, 10, -1, 3};
    vt[2] = '{2, 30, 2, 30, 1, 1, -1, 10, 9, 3};
    vt[3] = '{2, 30, 20, 20, 1, 0, 10, 28, -1, 6};
    vt[4] = '{3, 30, 2, 30, 1, 1, 14, 10, -1, 6};
    vt[5] = '{2, 3, 0, 0, 1, 0, -1, -1, -1, 0};
    vt[6] = '{2, 4, 0, 0, 1, 0, 10, -1, -1, 3};
    vt[7] = '{2, 30, 0, 0, 0, 0, -1, -1, -1, 0};
    vt[8] = '{2, 30, 0, 0, 1, 1, SKIP ? -1 : 10, -1, -1, SKIP ? 0 : 3};
    vt[9] = '{0, 0, 2, 30, 1, 0, -1, SKIP ? -1 : 10, -1, SKIP ? 0 : 3};

    repeat (2) @(posedge Clk);
    #1;
    chk("reset_S", int'(S), 0);
    chk("reset_R", int'(R), 0);
    chk("reset_Busy", int'(Busy), 0);
    chk("reset_Conflict", int'(Conflict), 0);
    Reset_L = 1'b1;
    E = 1'b1;
    repeat (3) step();
    chk("idle_after_release", int'(Busy), 0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      Q_Fb = vt[i].q0[0];
      E = vt[i].e[0];
      base = cyc;
      for (int t = 0; t < 60; t++) begin
        if (vt[i].exp_c == t) push(2, base + t, 1);
        if (vt[i].exp_r == t) push(1, base + t, 2);
        if (vt[i].exp_s == t) push(0, base + t, 2);
      end
      for (int t = 0; t < 48; t++) begin
        Set_Req = t >= vt[i].s_at && t < vt[i].s_at + vt[i].s_len;
        Rst_Req = t >= vt[i].r_at && t < vt[i].r_at + vt[i].r_len;
        step();
      end
      chk($sformatf("vec%0d_events_left", i), exp_q.size(), 0);
      chk($sformatf("vec%0d_busy_cycles", i), busy_cnt, vt[i].busy);
      exp_q.delete();
    end

    do_reset();
    Q_Fb = 1'b1;
    base = cyc;
    push(1, base + 14, 2);
    for (int t = 0; t < 40; t++) begin
      Rst_Req = t == 2 || t == 4 || t >= 6;
      step();
    end
    chk("bounce_events_left", exp_q.size(), 0);
    chk("bounce_busy_cycles", busy_cnt, 3);
    exp_q.delete();

    do_reset();
    E = 1'b0;
    Q_Fb = 1'b0;
    base = cyc;
    push(0, base + 26, 2);
    for (int t = 0; t < 40; t++) begin
      Set_Req = t >= 2 && t < 12;
      if (t == 24) chk("enable_low_no_busy", busy_cnt, 0);
      if (t == 25) E = 1'b1;
      step();
    end
    chk("enable_events_left", exp_q.size(), 0);
    chk("enable_busy_cycles", busy_cnt, 3);
    exp_q.delete();

    do_reset();
    Q_Fb = 1'b0;
    base = cyc;
    push(0, base + 10, 1);
    for (int t = 0; t < 11; t++) begin
      Set_Req = t >= 2 && t < 8;
      Rst_Req = t >= 4 && t < 10;
      step();
    end
    chk("second_s_cycle", int'(S), 1);
    #1;
    Reset_L = 1'b0;
    Set_Req = 1'b0;
    Rst_Req = 1'b0;
    #1;
    chk("async_reset_S", int'(S), 0);
    chk("async_reset_Busy", int'(Busy), 0);
    chk("async_reset_R", int'(R), 0);
    step();
    Reset_L = 1'b1;
    busy_cnt = 0;
    repeat (40) step();
    chk("reset_events_left", exp_q.size(), 0);
    chk("reset_pending_lost", busy_cnt, 0);
    exp_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
